// File: rtl/mult_8x8_seq.sv
// mult_8x8_seq: sequential shift-and-add unsigned multiplier.
//
// Ports:
//   clk      in   1         rising-edge clock
//   rst_n    in   1         asynchronous active-low reset
//   start    in   1         request a multiply (sampled only in IDLE)
//   a        in   WIDTH     multiplicand
//   b        in   WIDTH     multiplier
//   busy     out  1         high while iterating (RUN state)
//   done     out  1         one-cycle pulse when product is newly updated
//   product  out  2*WIDTH   result, held until the next completion
module mult_8x8_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 last;
    logic [2*WIDTH-1:0]   acc_sum;

    assign last    = (count_q == CW'(WIDTH - 1));
    // The add of the current multiplier bit; also feeds product on the final edge.
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        if (state_q == IDLE && start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
        end else if (state_q == RUN) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // Hold on the final edge; leaving RUN is what ends the count.
            count_d  = last ? count_q : count_q + 1'b1;
            if (last) product_d = acc_sum;
        end
        busy_d = (state_d == RUN);
        done_d = (state_q == RUN) && last;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
